// File: rtl/noc_switch_allocator.sv
// Switch allocator for a 5-port (N, S, E, W, L) wormhole router.
// Each output is arbitrated round-robin among head flits. A head-only winner then
// holds the output until its tail flit has crossed. Grants, valids and crossbar
// selects are combinational from the current requests.
module noc_switch_allocator (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  in_req,
  input  logic [14:0] in_dst,
  input  logic [4:0]  in_head,
  input  logic [4:0]  in_tail,
  input  logic [4:0]  out_ready,
  output logic [2:0]  N_port_select,
  output logic [2:0]  S_port_select,
  output logic [2:0]  E_port_select,
  output logic [2:0]  W_port_select,
  output logic [2:0]  L_port_select,
  output logic [4:0]  out_valid,
  output logic [4:0]  in_grant,
  output logic        err_o
);

  logic [4:0]      lock_q, lock_d;
  logic [4:0][2:0] owner_q, owner_d;
  logic [4:0][2:0] rr_q, rr_d;
  logic            err_q, err_d;

  logic [4:0][2:0] dst;
  logic [4:0]      legal;
  logic [4:0]      fire;
  logic [4:0][2:0] win;
  logic [4:0][2:0] sel;
  logic            err_now;

  // Per-input destination decode and legality (in range, no U-turn).
  for (genvar i = 0; i < 5; i++) begin : g_dec
    assign dst[i]   = in_dst[3*i +: 3];
    assign legal[i] = in_req[i] && (dst[i] <= 3'd4) && (dst[i] != 3'(i));
  end

  // Per-output winner: the owner when locked, else round-robin scan over head flits.
  always_comb begin
    logic       found;
    logic [3:0] sum;
    logic [2:0] idx;
    fire  = '0;
    win   = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (logic [2:0] o = 0; o < 5; o++) begin
      if (lock_q[o]) begin
        win[o]  = owner_q[o];
        fire[o] = legal[owner_q[o]] && (dst[owner_q[o]] == o) && out_ready[o];
      end else begin
        found = 1'b0;
        for (logic [2:0] k = 0; k < 5; k++) begin
          sum = {1'b0, rr_q[o]} + {1'b0, k};
          if (sum >= 4'd5) sum = sum - 4'd5;
          idx = sum[2:0];
          if (!found && legal[idx] && (dst[idx] == o) && in_head[idx]) begin
            found  = 1'b1;
            win[o] = idx;
          end
        end
        fire[o] = found && out_ready[o];
      end
    end
  end

  // Protocol errors seen this cycle: illegal route, headless flit to a free output,
  // or an owner steering away from the output it holds.
  always_comb begin
    err_now = 1'b0;
    for (logic [2:0] i = 0; i < 5; i++) begin
      if (in_req[i] && !legal[i]) err_now = 1'b1;
      for (logic [2:0] o = 0; o < 5; o++) begin
        if (legal[i] && (dst[i] == o) && !lock_q[o] && !in_head[i]) err_now = 1'b1;
      end
    end
    for (logic [2:0] o = 0; o < 5; o++) begin
      if (lock_q[o] && in_req[owner_q[o]] && (dst[owner_q[o]] != o)) err_now = 1'b1;
    end
  end

  // Outputs; reset forces the idle pattern regardless of inputs or stale state.
  always_comb begin
    in_grant = '0;
    for (logic [2:0] o = 0; o < 5; o++) begin
      if (fire[o]) in_grant[win[o]] = 1'b1;
      if (rst)           sel[o] = o;
      else if (fire[o])  sel[o] = win[o];
      else if (lock_q[o]) sel[o] = owner_q[o];
      else               sel[o] = o;  // crossbar idle code
    end
    if (rst) in_grant = '0;
    out_valid = rst ? 5'b0 : fire;
    err_o     = !rst && (err_q || err_now);
  end

  assign N_port_select = sel[0];
  assign S_port_select = sel[1];
  assign E_port_select = sel[2];
  assign W_port_select = sel[3];
  assign L_port_select = sel[4];

  // Next-state: lock on head-only, release on tail, advance pointer past a head winner.
  always_comb begin
    lock_d  = lock_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    err_d   = err_q || err_now;
    for (logic [2:0] o = 0; o < 5; o++) begin
      if (fire[o]) begin
        if (in_tail[win[o]]) begin
          lock_d[o] = 1'b0;
        end else if (in_head[win[o]]) begin
          lock_d[o]  = 1'b1;
          owner_d[o] = win[o];
        end
        if (in_head[win[o]]) rr_d[o] = (win[o] == 3'd4) ? 3'd0 : win[o] + 3'd1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q  <= '0;
      owner_q <= {3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
      rr_q    <= {3'd0, 3'd0, 3'd0, 3'd0, 3'd1};
      err_q   <= 1'b0;
    end else begin
      lock_q  <= lock_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_noc_switch_allocator.sv
// Directed bench for noc_switch_allocator: inputs change 1 ns after the rising
// edge, outputs are sampled on the falling edge.
module tb_noc_switch_allocator;

  logic        clk;
  logic        rst;
  logic [4:0]  in_req, in_head, in_tail, out_ready;
  logic [14:0] in_dst;
  logic [2:0]  N_port_select, S_port_select, E_port_select, W_port_select, L_port_select;
  logic [4:0]  out_valid, in_grant;
  logic        err_o;
  logic [14:0] sels;

  int errors = 0;
  int checks = 0;

  noc_switch_allocator dut (
    .clk           (clk),
    .rst           (rst),
    .in_req        (in_req),
    .in_dst        (in_dst),
    .in_head       (in_head),
    .in_tail       (in_tail),
    .out_ready     (out_ready),
    .N_port_select (N_port_select),
    .S_port_select (S_port_select),
    .E_port_select (E_port_select),
    .W_port_select (W_port_select),
    .L_port_select (L_port_select),
    .out_valid     (out_valid),
    .in_grant      (in_grant),
    .err_o         (err_o)
  );

  assign sels = {L_port_select, W_port_select, E_port_select, S_port_select, N_port_select};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_in();
    in_req    = '0;
    in_dst    = '0;
    in_head   = '0;
    in_tail   = '0;
    out_ready = 5'b11111;
  endtask

  task automatic set_req(input int i, input int d, input bit h, input bit t);
    in_req[i]        = 1'b1;
    in_dst[3*i +: 3] = 3'(d);
    in_head[i]       = h;
    in_tail[i]       = t;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_in();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_req    = 5'b11111;
    in_dst    = 15'h7FFF;
    in_head   = 5'b11111;
    in_tail   = 5'b00000;
    out_ready = 5'b11111;
    @(negedge clk);
    if (out_valid !== 5'b0) begin
      errors++; $display("FAIL rst_valid got=%b want=00000", out_valid);
    end
    checks++;
    if (in_grant !== 5'b0) begin
      errors++; $display("FAIL rst_grant got=%b want=00000", in_grant);
    end
    checks++;
    if (err_o !== 1'b0) begin
      errors++; $display("FAIL rst_err got=%b want=0", err_o);
    end
    checks++;
    if (sels !== {3'd4, 3'd3, 3'd2, 3'd1, 3'd0}) begin
      errors++; $display("FAIL rst_sels got=%h want=%h", sels, {3'd4, 3'd3, 3'd2, 3'd1, 3'd0});
    end
    checks++;
    cyc();
    rst = 1'b0;
    clear_in();
    @(negedge clk);
    if (sels !== {3'd4, 3'd3, 3'd2, 3'd1, 3'd0} || out_valid !== 5'b0 || err_o !== 1'b0) begin
      errors++; $display("FAIL rst_idle got sels=%h valid=%b err=%b", sels, out_valid, err_o);
    end
    checks++;
    cyc();
  endtask

  task automatic test_single();
    do_reset();
    set_req(4, 2, 1'b1, 1'b1);
    @(negedge clk);
    if (E_port_select !== 3'd4) begin
      errors++; $display("FAIL single_sel got=%0d want=4", E_port_select);
    end
    checks++;
    if (out_valid !== 5'b00100) begin
      errors++; $display("FAIL single_valid got=%b want=00100", out_valid);
    end
    checks++;
    if (in_grant !== 5'b10000) begin
      errors++; $display("FAIL single_grant got=%b want=10000", in_grant);
    end
    checks++;
    cyc();
    clear_in();
    @(negedge clk);
    if (E_port_select !== 3'd2 || out_valid !== 5'b0) begin
      errors++; $display("FAIL single_nolock got sel=%0d valid=%b want sel=2 valid=00000",
                         E_port_select, out_valid);
    end
    checks++;
    cyc();
  endtask

  task automatic test_contention();
    int order [6] = '{0, 1, 3, 0, 1, 3};
    do_reset();
    set_req(0, 4, 1'b1, 1'b1);
    set_req(1, 4, 1'b1, 1'b1);
    set_req(3, 4, 1'b1, 1'b1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (L_port_select !== 3'(order[c]) || in_grant !== 5'(1 << order[c])
          || out_valid !== 5'b10000) begin
        errors++;
        $display("FAIL contention_c%0d got sel=%0d grant=%b valid=%b want sel=%0d", c,
                 L_port_select, in_grant, out_valid, order[c]);
      end
      checks++;
      cyc();
    end
    clear_in();
  endtask

  task automatic test_wormhole();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      clear_in();
      set_req(2, 0, 1'b1, 1'b1);
      if (c < 3) set_req(1, 0, c == 0, c == 2);
      @(negedge clk);
      if (c < 3) begin
        if (N_port_select !== 3'd1 || in_grant !== 5'b00010) begin
          errors++; $display("FAIL wormhole_c%0d got sel=%0d grant=%b want sel=1 grant=00010",
                             c, N_port_select, in_grant);
        end
      end else begin
        if (N_port_select !== 3'd2 || in_grant !== 5'b00100) begin
          errors++; $display("FAIL wormhole_c%0d got sel=%0d grant=%b want sel=2 grant=00100",
                             c, N_port_select, in_grant);
        end
      end
      checks++;
      cyc();
    end
    clear_in();
    @(negedge clk);
    if (err_o !== 1'b0) begin
      errors++; $display("FAIL wormhole_err got=%b want=0", err_o);
    end
    checks++;
    cyc();
  endtask

  task automatic test_backpressure();
    do_reset();
    set_req(1, 0, 1'b1, 1'b0);
    @(negedge clk);
    if (in_grant !== 5'b00010) begin
      errors++; $display("FAIL bp_head got=%b want=00010", in_grant);
    end
    checks++;
    cyc();
    clear_in();
    set_req(1, 0, 1'b0, 1'b0);
    out_ready = 5'b11110;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (out_valid[0] !== 1'b0 || in_grant !== 5'b0 || N_port_select !== 3'd1) begin
        errors++; $display("FAIL bp_stall_c%0d got valid=%b grant=%b sel=%0d want 0/00000/1",
                           c, out_valid, in_grant, N_port_select);
      end
      checks++;
      cyc();
    end
    out_ready = 5'b11111;
    in_tail[1] = 1'b1;
    @(negedge clk);
    if (out_valid !== 5'b00001 || in_grant !== 5'b00010 || N_port_select !== 3'd1) begin
      errors++; $display("FAIL bp_resume got valid=%b grant=%b sel=%0d", out_valid, in_grant,
                         N_port_select);
    end
    checks++;
    cyc();
    clear_in();
    @(negedge clk);
    if (N_port_select !== 3'd0 || err_o !== 1'b0) begin
      errors++; $display("FAIL bp_release got sel=%0d err=%b want 0/0", N_port_select, err_o);
    end
    checks++;
    cyc();
  endtask

  task automatic test_errors();
    // U-turn, then sticky check
    do_reset();
    set_req(3, 3, 1'b1, 1'b1);
    @(negedge clk);
    if (in_grant !== 5'b0 || out_valid !== 5'b0 || err_o !== 1'b1) begin
      errors++; $display("FAIL err_uturn got grant=%b valid=%b err=%b", in_grant, out_valid, err_o);
    end
    checks++;
    cyc();
    clear_in();
    cyc();
    @(negedge clk);
    if (err_o !== 1'b1) begin
      errors++; $display("FAIL err_sticky got=%b want=1", err_o);
    end
    checks++;
    // out-of-range destination
    do_reset();
    set_req(0, 5, 1'b1, 1'b1);
    @(negedge clk);
    if (in_grant !== 5'b0 || out_valid !== 5'b0 || err_o !== 1'b1) begin
      errors++; $display("FAIL err_range got grant=%b valid=%b err=%b", in_grant, out_valid, err_o);
    end
    checks++;
    cyc();
    // body flit to an unlocked output
    do_reset();
    @(negedge clk);
    if (err_o !== 1'b0) begin
      errors++; $display("FAIL err_cleared got=%b want=0", err_o);
    end
    checks++;
    set_req(0, 2, 1'b0, 1'b0);
    @(negedge clk);
    if (in_grant !== 5'b0 || out_valid !== 5'b0 || err_o !== 1'b1) begin
      errors++; $display("FAIL err_body got grant=%b valid=%b err=%b", in_grant, out_valid, err_o);
    end
    checks++;
    cyc();
    do_reset();
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_req(0, 2, 1'b1, 1'b0);
    @(negedge clk);
    if (E_port_select !== 3'd0 || in_grant !== 5'b00001) begin
      errors++; $display("FAIL mid_head got sel=%0d grant=%b", E_port_select, in_grant);
    end
    checks++;
    cyc();
    clear_in();
    @(negedge clk);
    if (E_port_select !== 3'd0 || out_valid !== 5'b0) begin
      errors++; $display("FAIL mid_locked got sel=%0d valid=%b want 0/00000", E_port_select,
                         out_valid);
    end
    checks++;
    do_reset();
    set_req(4, 0, 1'b1, 1'b1);
    @(negedge clk);
    if (N_port_select !== 3'd4 || out_valid !== 5'b00001 || in_grant !== 5'b10000
        || E_port_select !== 3'd2) begin
      errors++; $display("FAIL mid_after got nsel=%0d esel=%0d valid=%b grant=%b",
                         N_port_select, E_port_select, out_valid, in_grant);
    end
    checks++;
    cyc();
    clear_in();
    set_req(0, 2, 1'b0, 1'b1);
    @(negedge clk);
    if (in_grant !== 5'b0 || err_o !== 1'b1) begin
      errors++; $display("FAIL mid_stale_body got grant=%b err=%b want 00000/1", in_grant, err_o);
    end
    checks++;
    cyc();
    clear_in();
  endtask

  initial begin
    rst = 1'b1;
    clear_in();
    test_reset();
    test_single();
    test_contention();
    test_wormhole();
    test_backpressure();
    test_errors();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
